// File: rtl/regfile_wr_if.sv
// Write-port bundle between the audio processing units, the arbiter and the register file.
// The master side drives requests; the slave side (the arbiter) returns grants and the file's write controls.
interface regfile_wr_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      clear;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic [ADDR_W-1:0]         rf_addr_w;
  logic [DATA_W-1:0]         rf_data_w;
  logic                      rf_wr;

  modport master (
    output req, req_addr, req_data, clear,
    input  gnt, busy, rf_addr_w, rf_data_w, rf_wr
  );

  modport slave (
    input  req, req_addr, req_data, clear,
    output gnt, busy, rf_addr_w, rf_data_w, rf_wr
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the audio register file write port, with a zeroing sweep
// after reset or on request. All outputs are registered one cycle after arbitration.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wr_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {CLEAR, ARB} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  cnt, cnt_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;

  logic [NUM_REQ-1:0] elig;
  logic [PTR_W:0]     pick;
  int                 win;

  logic               vld_p0, vld_p1;
  logic [ADDR_W-1:0]  addr_p0, addr_p1;
  logic [DATA_W-1:0]  data_p0, data_p1;
  logic [NUM_REQ-1:0] gnt_p0, gnt_p1;
  logic               busy_p0, busy_p1;

  // Returns {found, index} of the first set bit at or above ptr, wrapping.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (mask[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  // Stage p0: arbitration / sweep decision from current state and inputs
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    vld_p0     = 1'b0;
    addr_p0    = addr_p1;
    data_p0    = data_p1;
    gnt_p0     = '0;
    busy_p0    = 1'b0;
    // The requester being acknowledged right now must not win again this cycle.
    elig       = bus.req & ~gnt_p1;
    pick       = rr_pick(elig, rr_ptr);
    win        = int'(pick[PTR_W-1:0]);

    unique case (state)
      CLEAR: begin
        busy_p0 = 1'b1;
        vld_p0  = 1'b1;
        data_p0 = '0;
        if (bus.clear) begin
          addr_p0 = '0;
          cnt_nxt = ADDR_W'(1);
        end else begin
          addr_p0 = cnt;
          if (cnt == LAST_ADDR) begin
            cnt_nxt   = '0;
            state_nxt = ARB;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ARB: begin
        if (bus.clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          busy_p0   = 1'b1;
        end else if (pick[PTR_W]) begin
          vld_p0      = 1'b1;
          addr_p0     = bus.req_addr[win*ADDR_W +: ADDR_W];
          data_p0     = bus.req_data[win*DATA_W +: DATA_W];
          gnt_p0[win] = 1'b1;
          rr_ptr_nxt  = PTR_W'((win + 1) % NUM_REQ);
        end
      end
    endcase
  end

  // Stage p1: registered outputs and FSM state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      rr_ptr  <= '0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      gnt_p1  <= '0;
      busy_p1 <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rr_ptr  <= rr_ptr_nxt;
      vld_p1  <= vld_p0;
      addr_p1 <= addr_p0;
      data_p1 <= data_p0;
      gnt_p1  <= gnt_p0;
      busy_p1 <= busy_p0;
    end
  end

  assign bus.rf_wr     = vld_p1;
  assign bus.rf_addr_w = addr_p1;
  assign bus.rf_data_w = data_p1;
  assign bus.gnt       = gnt_p1;
  assign bus.busy      = busy_p1;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed stimulus queues expected writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_regfile_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic        busy;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;

  logic [3:0]  a_tab [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
  logic [15:0] d_tab [4] = '{16'hC05A, 16'hC15A, 16'hC25A, 16'hC35A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d, input logic [3:0] g, input logic b);
    wr_t e;
    e.addr = a; e.data = d; e.gnt = g; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) push(4'(i), 16'h0000, 4'b0000, 1'b1);
  endtask

  task automatic push_req(input int i, input logic [3:0] g);
    push(a_tab[i], d_tab[i], g, 1'b0);
  endtask

  task automatic load_tab();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = a_tab[i];
      bus.req_data[i*DATA_W +: DATA_W] = d_tab[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"},   32'(bus.rf_wr),     32'h0);
    check({tag, "_addr"}, 32'(bus.rf_addr_w), 32'h0);
    check({tag, "_data"}, 32'(bus.rf_data_w), 32'h0);
    check({tag, "_gnt"},  32'(bus.gnt),       32'h0);
    check({tag, "_busy"}, 32'(bus.busy),      32'h1);
  endtask

  // Monitor: every issued write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.rf_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h gnt %b, required no write (t=%0t)",
                 bus.rf_addr_w, bus.rf_data_w, bus.gnt, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.rf_addr_w), 32'(mon_e.addr));
        check("wr_data", 32'(bus.rf_data_w), 32'(mon_e.data));
        check("wr_gnt",  32'(bus.gnt),       32'(mon_e.gnt));
        check("wr_busy", 32'(bus.busy),      32'(mon_e.busy));
      end
    end else begin
      check("idle_gnt", 32'(bus.gnt), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    bus.req      = '0;
    bus.clear    = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (3) step();
    check_reset_outputs("reset");

    // Sweep after reset release: 16 zero writes, busy drops in the 17th cycle.
    push_sweep(16);
    rst = 1'b1;
    repeat (17) step();
    check("sweep_busy_drop", 32'(bus.busy),  32'h0);
    check("sweep_end_wr",    32'(bus.rf_wr), 32'h0);

    // Lone requester: write every other cycle.
    load_tab();
    bus.req_addr[3:0]  = 4'd3;
    bus.req_data[15:0] = 16'hA5A5;
    bus.req = 4'b0001;
    push(4'd3, 16'hA5A5, 4'b0001, 1'b0);
    push(4'd3, 16'hA5A5, 4'b0001, 1'b0);
    step();
    step();
    check("lone_gap_wr", 32'(bus.rf_wr), 32'h0);
    step();
    bus.req = '0;
    step();

    // Requester 3 alone moves the pointer to 0, then all four rotate.
    load_tab();
    bus.req = 4'b1000;
    push_req(3, 4'b1000);
    step();
    bus.req = 4'b1111;
    push_req(0, 4'b0001);
    push_req(1, 4'b0010);
    push_req(2, 4'b0100);
    push_req(3, 4'b1000);
    push_req(0, 4'b0001);
    repeat (5) step();
    bus.req = '0;
    step();
    check("drain_wr", 32'(bus.rf_wr), 32'h0);

    // Last winner 1 puts the pointer at 2; 0011 then serves 0 before 1.
    bus.req = 4'b0010;
    push_req(1, 4'b0010);
    step();
    bus.req = '0;
    step();
    bus.req = 4'b0011;
    push_req(0, 4'b0001);
    push_req(1, 4'b0010);
    step();
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    step();

    // Clear beats a pending request; the request is served after the sweep.
    bus.req   = 4'b0100;
    bus.clear = 1'b1;
    step();
    check("clear_busy", 32'(bus.busy),  32'h1);
    check("clear_wr",   32'(bus.rf_wr), 32'h0);
    bus.clear = 1'b0;
    push_sweep(16);
    push_req(2, 4'b0100);
    repeat (17) step();
    bus.req = '0;
    step();
    check("post_clear_busy", 32'(bus.busy), 32'h0);

    // Reset in the middle of a sweep (cnt=9) restarts it from address 0.
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    push_sweep(9);
    repeat (9) step();
    rst = 1'b0;
    step();
    check_reset_outputs("rst_sweep");
    rst = 1'b1;
    push_sweep(16);
    repeat (17) step();
    check("resweep_busy", 32'(bus.busy), 32'h0);

    // Reset during a grant cycle; the held request is served after the new sweep.
    bus.req = 4'b0001;
    push_req(0, 4'b0001);
    step();
    rst = 1'b0;
    step();
    check_reset_outputs("rst_grant");
    step();
    rst = 1'b1;
    push_sweep(16);
    push_req(0, 4'b0001);
    repeat (17) step();
    bus.req = '0;
    repeat (2) step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
